bsg_axil_irq_notifier: RTL and testbench



---
 rtl/bsg_axil_irq_notifier.sv | 174 +++++++++++++++++
 tb/tb_bsg_axil_irq_notifier.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bsg_axil_irq_notifier.sv
// rtl/bsg_axil_irq_notifier.sv - PLIC target level/ID changes to AXI4-Lite write notifications
// Round-robin across targets, coalesces changes, retries errored writes a bounded number of times.
module bsg_axil_irq_notifier #(
  parameter int num_targets_p     = 2,
  parameter int id_width_p        = 1,
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32,
  parameter logic [31:0] base_addr_p = 32'h300000,
  parameter int stride_p          = 8,
  parameter int max_retry_p       = 3,
  localparam int idx_w_lp   = (num_targets_p == 1) ? 1 : $clog2(num_targets_p),
  localparam int retry_w_lp = (max_retry_p + 1 == 1) ? 1 : $clog2(max_retry_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [num_targets_p-1:0]       irq_i,
  input  logic [id_width_p-1:0]          irq_id_i [num_targets_p],
  output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
  output logic [2:0]                     m_axil_awprot_o,
  output logic                           m_axil_awvalid_o,
  input  logic                           m_axil_awready_i,
  output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
  output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
  output logic                           m_axil_wvalid_o,
  input  logic                           m_axil_wready_i,
  input  logic [1:0]                     m_axil_bresp_i,
  input  logic                           m_axil_bvalid_i,
  output logic                           m_axil_bready_o,
  output logic                           err_v_o,
  output logic [idx_w_lp-1:0]            err_target_o
);

  if (axil_data_width_p < id_width_p + 1) begin : g_bad_data_width
    $error("axil_data_width_p must be at least id_width_p+1");
  end
  if ((stride_p % (axil_data_width_p / 8)) != 0) begin : g_bad_stride
    $error("stride_p must be a multiple of axil_data_width_p/8");
  end

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_e;

  localparam logic [idx_w_lp-1:0]   last_idx_lp  = idx_w_lp'(num_targets_p - 1);
  localparam logic [retry_w_lp-1:0] max_retry_lp = retry_w_lp'(max_retry_p);

  state_e                         state_q, state_d;
  logic [idx_w_lp-1:0]            idx_q, idx_d, ptr_q, ptr_d;
  logic [axil_addr_width_p-1:0]   addr_q, addr_d;
  logic [axil_data_width_p-1:0]   data_q, data_d;
  logic                           awv_q, awv_d, wv_q, wv_d;
  logic [retry_w_lp-1:0]          retry_q, retry_d;
  logic                           err_v_q, err_v_d;
  logic [idx_w_lp-1:0]            err_target_q, err_target_d;
  logic [id_width_p:0]            snap_q [num_targets_p];
  logic [id_width_p:0]            snap_d [num_targets_p];

  logic [num_targets_p-1:0]       pending;
  logic [idx_w_lp-1:0]            grant, cand, next_idx;
  logic                           found;

  always_comb begin
    for (int t = 0; t < num_targets_p; t++) begin
      pending[t] = ({irq_i[t], irq_id_i[t]} != snap_q[t]);
    end
  end

  // Search starts at the priority pointer and wraps, so the last-served target goes last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = ptr_q;
    for (int i = 0; i < num_targets_p; i++) begin
      if (!found && pending[cand]) begin
        grant = cand;
        found = 1'b1;
      end
      cand = (cand == last_idx_lp) ? '0 : cand + idx_w_lp'(1);
    end
  end

  assign next_idx = (idx_q == last_idx_lp) ? '0 : idx_q + idx_w_lp'(1);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    addr_d       = addr_q;
    data_d       = data_q;
    awv_d        = awv_q;
    wv_d         = wv_q;
    retry_d      = retry_q;
    err_v_d      = 1'b0;
    err_target_d = err_target_q;
    snap_d       = snap_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d         = grant;
          addr_d        = axil_addr_width_p'(64'(base_addr_p) + 64'(grant) * 64'(stride_p));
          data_d        = axil_data_width_p'({irq_id_i[grant], irq_i[grant]});
          snap_d[grant] = {irq_i[grant], irq_id_i[grant]};
          awv_d         = 1'b1;
          wv_d          = 1'b1;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (m_axil_awready_i) awv_d = 1'b0;
        if (m_axil_wready_i)  wv_d  = 1'b0;
        if (!awv_d && !wv_d) state_d = RESP;
      end
      RESP: begin
        if (m_axil_bvalid_i) begin
          if (m_axil_bresp_i == 2'b00) begin
            state_d = IDLE;
            retry_d = '0;
            ptr_d   = next_idx;
          end else if (retry_q < max_retry_lp) begin
            state_d = SEND;
            awv_d   = 1'b1;
            wv_d    = 1'b1;
            retry_d = retry_q + retry_w_lp'(1);
          end else begin
            // Snapshot already holds the dropped value, so this change is not re-sent.
            state_d      = IDLE;
            retry_d      = '0;
            ptr_d        = next_idx;
            err_v_d      = 1'b1;
            err_target_d = idx_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ptr_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      awv_q        <= 1'b0;
      wv_q         <= 1'b0;
      retry_q      <= '0;
      err_v_q      <= 1'b0;
      err_target_q <= '0;
      for (int t = 0; t < num_targets_p; t++) snap_q[t] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      awv_q        <= awv_d;
      wv_q         <= wv_d;
      retry_q      <= retry_d;
      err_v_q      <= err_v_d;
      err_target_q <= err_target_d;
      for (int t = 0; t < num_targets_p; t++) snap_q[t] <= snap_d[t];
    end
  end

  assign m_axil_awaddr_o  = addr_q;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_awvalid_o = awv_q;
  assign m_axil_wdata_o   = data_q;
  assign m_axil_wstrb_o   = '1;
  assign m_axil_wvalid_o  = wv_q;
  assign m_axil_bready_o  = (state_q == RESP);
  assign err_v_o          = err_v_q;
  assign err_target_o     = err_target_q;

endmodule

// File: tb/tb_bsg_axil_irq_notifier.sv
// tb/tb_bsg_axil_irq_notifier.sv - directed self-checking bench for bsg_axil_irq_notifier
module tb_bsg_axil_irq_notifier;

  logic        clk;
  logic        rst_n;
  logic [1:0]  irq;
  logic [0:0]  irq_id [2];
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        err_v;
  logic [0:0]  err_target;

  int total  = 0;
  int passed = 0;

  bsg_axil_irq_notifier dut (
    .clk_i(clk), .rst_ni(rst_n), .irq_i(irq), .irq_id_i(irq_id),
    .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid),
    .m_axil_awready_i(awready), .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb),
    .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wready), .m_axil_bresp_i(bresp),
    .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
    .err_v_o(err_v), .err_target_o(err_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Acts as the slave for one write: awready after aw_st cycles, wready after w_st cycles.
  task automatic serve(input string tag, input int aw_st, input int w_st, input logic [1:0] resp,
                       input logic [31:0] ea, input logic [31:0] ed, input logic exp_err,
                       input logic pulse0);
    int  t, c, awcyc;
    bit  aw_done, w_done;
    t = 0;
    while (!awvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, ":awvalid"}, awvalid, 1);
    chk({tag, ":wvalid"}, wvalid, 1);
    chk({tag, ":bready_send"}, bready, 0);
    aw_done = 0; w_done = 0; c = 0; awcyc = 0;
    while (!(aw_done && w_done) && c < 40) begin
      chk({tag, ":awaddr"}, awaddr, ea);
      chk({tag, ":wdata"}, wdata, ed);
      chk({tag, ":awvalid_hold"}, awvalid, !aw_done);
      chk({tag, ":wvalid_hold"}, wvalid, !w_done);
      if (pulse0 && c == 0) irq[0] = 1'b1;
      if (pulse0 && c == 1) irq[0] = 1'b0;
      awready = !aw_done && (c >= aw_st);
      wready  = !w_done && (c >= w_st);
      if (awvalid) awcyc++;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge clk);
      c++;
    end
    awready = 1'b0;
    wready  = 1'b0;
    chk({tag, ":awvalid_cycles"}, awcyc, aw_st + 1);
    chk({tag, ":bready"}, bready, 1);
    chk({tag, ":awvalid_resp"}, awvalid, 0);
    chk({tag, ":wvalid_resp"}, wvalid, 0);
    bvalid = 1'b1;
    bresp  = resp;
    @(negedge clk);
    bvalid = 1'b0;
    bresp  = 2'b00;
    chk({tag, ":err_v"}, err_v, exp_err);
    if (exp_err) chk({tag, ":err_target"}, err_target, 0);
  endtask

  task automatic quiet(input string tag, input int n);
    bit seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (awvalid || wvalid || err_v) seen = 1;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    rst_n = 1'b0; irq = 2'b00; irq_id[0] = 1'b0; irq_id[1] = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst:awvalid", awvalid, 0);
    chk("rst:wvalid", wvalid, 0);
    chk("rst:bready", bready, 0);
    chk("rst:err_v", err_v, 0);
    chk("rst:awaddr", awaddr, 0);
    chk("rst:wdata", wdata, 0);
    chk("rst:err_target", err_target, 0);
    chk("const:awprot", awprot, 0);
    chk("const:wstrb", wstrb, 4'hf);
    rst_n = 1'b1;
    quiet("rst:idle", 3);

    // single target, zero-wait slave
    irq[1] = 1'b1; irq_id[1] = 1'b1;
    serve("single", 0, 0, 2'b00, 32'h300008, 32'h3, 1'b0, 1'b0);
    quiet("single:no_repeat", 5);

    // both change together; target 0 first, skewed handshakes
    irq[0] = 1'b1; irq[1] = 1'b0; irq_id[1] = 1'b0;
    serve("fair0", 2, 4, 2'b00, 32'h300000, 32'h1, 1'b0, 1'b0);
    serve("fair1", 0, 0, 2'b00, 32'h300008, 32'h0, 1'b0, 1'b0);
    quiet("fair:idle", 3);

    // coalescing: target 0 pulse during target 1 transaction is not sent
    irq[0] = 1'b0;
    serve("coal_clr0", 0, 0, 2'b00, 32'h300000, 32'h0, 1'b0, 1'b0);
    irq[1] = 1'b1;
    serve("coal_t1", 3, 3, 2'b00, 32'h300008, 32'h1, 1'b0, 1'b1);
    quiet("coal:no_t0_write", 5);
    irq[0] = 1'b1;
    serve("coal_t0", 0, 0, 2'b00, 32'h300000, 32'h1, 1'b0, 1'b0);
    quiet("coal:single_write", 5);

    // SLVERR twice then OKAY
    irq_id[1] = 1'b1;
    serve("retry_a", 0, 0, 2'b10, 32'h300008, 32'h3, 1'b0, 1'b0);
    serve("retry_b", 0, 0, 2'b10, 32'h300008, 32'h3, 1'b0, 1'b0);
    serve("retry_c", 1, 0, 2'b00, 32'h300008, 32'h3, 1'b0, 1'b0);
    quiet("retry:idle", 4);

    // DECERR forever: four writes then the drop pulse
    irq[0] = 1'b0;
    serve("exh_a", 0, 0, 2'b11, 32'h300000, 32'h0, 1'b0, 1'b0);
    serve("exh_b", 0, 0, 2'b11, 32'h300000, 32'h0, 1'b0, 1'b0);
    serve("exh_c", 0, 0, 2'b11, 32'h300000, 32'h0, 1'b0, 1'b0);
    serve("exh_d", 0, 0, 2'b11, 32'h300000, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("exh:err_pulse_end", err_v, 0);
    quiet("exh:no_resend", 4);
    irq[0] = 1'b1;
    serve("exh_new", 0, 0, 2'b00, 32'h300000, 32'h1, 1'b0, 1'b0);

    // async reset while SEND is stalled
    irq[1] = 1'b0;
    @(negedge clk);
    chk("arst:awvalid_before", awvalid, 1);
    chk("arst:awaddr_before", awaddr, 32'h300008);
    chk("arst:wdata_before", wdata, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst:awvalid", awvalid, 0);
    chk("arst:wvalid", wvalid, 0);
    chk("arst:bready", bready, 0);
    irq_id[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    serve("arst_new", 0, 0, 2'b00, 32'h300000, 32'h1, 1'b0, 1'b0);
    quiet("arst:idle", 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
